d20_roll_tally: RTL and testbench

- Downstream consumer of the d20 roll stage; it takes each completed roll (face, modified total, hit flag) as one strobe.
- Keeps saturating statistics: rolls, hits, natural 20s, natural 1s, invalid faces, current and best hit streak.
- Logs the last 2**LOG_DEPTH valid rolls in a circular buffer, readable by age over a request/valid handshake.
- Feeds the debug/readout path after the roller so a bench or host can audit roll sequences without probing internals.

---
 rtl/d20_roll_tally.sv | 165 ++++++++++++++++
 tb/tb_d20_roll_tally.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/d20_roll_tally.sv
// Roll statistics and circular roll log fed by the d20 roll stage.
// Optional feature: define D20_TALLY_SUM_EN to add the sum_final accumulator.
module d20_roll_tally #(
  parameter int NUM_BITS  = 8,
  parameter int LOG_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             roll_valid,
  input  logic [4:0]                       random_num,
  input  logic signed [NUM_BITS-1:0]       final_num,
  input  logic                             hit,
  input  logic                             clear,
  input  logic                             rd_req,
  input  logic [LOG_DEPTH-1:0]             rd_age,
  output logic                             rd_valid,
  output logic                             rd_err,
  output logic [4:0]                       rd_face,
  output logic signed [NUM_BITS-1:0]       rd_final,
  output logic                             rd_hit,
  output logic [CNT_W-1:0]                 roll_count,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [CNT_W-1:0]                 nat20_count,
  output logic [CNT_W-1:0]                 nat1_count,
  output logic [CNT_W-1:0]                 bad_count,
  output logic [CNT_W-1:0]                 streak,
  output logic [CNT_W-1:0]                 best_streak,
`ifdef D20_TALLY_SUM_EN
  output logic signed [CNT_W+NUM_BITS-1:0] sum_final,
`endif
  output logic [LOG_DEPTH:0]               log_fill
);

  localparam int DEPTH   = 1 << LOG_DEPTH;
  localparam int ENTRY_W = 5 + NUM_BITS + 1;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  rd_state_t            rd_state_reg;
  logic [LOG_DEPTH-1:0] wr_ptr_reg;
  logic [ENTRY_W-1:0]   log_mem [DEPTH];
  logic [DEPTH-1:0]     log_we;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [ENTRY_W-1:0]   rd_entry;
  logic [LOG_DEPTH-1:0] rd_idx;
  logic                 rd_miss;
  logic                 soft_rst;
  logic                 face_ok;
  logic                 valid_roll;
  logic                 bad_roll;
  logic [CNT_W-1:0]     streak_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // clear behaves exactly like reset and also swallows a same-cycle roll
  assign soft_rst    = reset || clear;
  assign face_ok     = (random_num >= 5'd1) && (random_num <= 5'd20);
  assign valid_roll  = roll_valid && !clear && face_ok;
  assign bad_roll    = roll_valid && !clear && !face_ok;
  assign streak_next = sat_inc(streak);
  assign wr_entry    = {random_num, final_num, hit};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_log_we
      assign log_we[gi] = valid_roll && (wr_ptr_reg == LOG_DEPTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (soft_rst) begin
        log_mem[i] <= '0;
      end else if (log_we[i]) begin
        log_mem[i] <= wr_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      roll_count  <= '0;
      hit_count   <= '0;
      nat20_count <= '0;
      nat1_count  <= '0;
      bad_count   <= '0;
      streak      <= '0;
      best_streak <= '0;
      log_fill    <= '0;
      wr_ptr_reg  <= '0;
    end else begin
      if (bad_roll) begin
        bad_count <= sat_inc(bad_count);
      end
      if (valid_roll) begin
        roll_count <= sat_inc(roll_count);
        if (hit) begin
          hit_count <= sat_inc(hit_count);
          streak    <= streak_next;
          if (streak_next > best_streak) begin
            best_streak <= streak_next;
          end
        end else begin
          streak <= '0;
        end
        if (random_num == 5'd20) nat20_count <= sat_inc(nat20_count);
        if (random_num == 5'd1)  nat1_count  <= sat_inc(nat1_count);
        if (log_fill != (LOG_DEPTH+1)'(DEPTH)) begin
          log_fill <= log_fill + 1'b1;
        end
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
    end
  end

`ifdef D20_TALLY_SUM_EN
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      sum_final <= '0;
    end else if (valid_roll) begin
      sum_final <= sum_final + (CNT_W+NUM_BITS)'(final_num);
    end
  end
`endif

  // Entry is resolved at the request edge, so a same-cycle write is not yet visible
  assign rd_idx   = wr_ptr_reg - LOG_DEPTH'(1) - rd_age;
  assign rd_entry = log_mem[rd_idx];
  assign rd_miss  = ({1'b0, rd_age} >= log_fill);

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      rd_state_reg <= RD_IDLE;
      rd_valid     <= 1'b0;
      rd_err       <= 1'b0;
      rd_face      <= '0;
      rd_final     <= '0;
      rd_hit       <= 1'b0;
    end else begin
      case (rd_state_reg)
        RD_IDLE: begin
          if (rd_req) begin
            rd_state_reg <= RD_RESP;
            rd_valid     <= 1'b1;
            rd_err       <= rd_miss;
            rd_face      <= rd_miss ? 5'd0 : rd_entry[ENTRY_W-1 -: 5];
            rd_final     <= rd_miss ? '0 : rd_entry[NUM_BITS:1];
            rd_hit       <= rd_miss ? 1'b0 : rd_entry[0];
          end
        end
        RD_RESP: begin
          rd_state_reg <= RD_IDLE;
          rd_valid     <= 1'b0;
        end
        default: begin
          rd_state_reg <= RD_IDLE;
          rd_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d20_roll_tally.sv
// Self-checking bench for d20_roll_tally: directed test-plan steps plus random rolls/reads
// against a queue-based reference model.
module tb_d20_roll_tally;

  localparam int DEPTH = 8;

  logic              clk;
  logic              reset;
  logic              roll_valid;
  logic [4:0]        random_num;
  logic signed [7:0] final_num;
  logic              hit;
  logic              clear;
  logic              rd_req;
  logic [2:0]        rd_age;
  logic              rd_valid;
  logic              rd_err;
  logic [4:0]        rd_face;
  logic signed [7:0] rd_final;
  logic              rd_hit;
  logic [15:0]       roll_count, hit_count, nat20_count, nat1_count, bad_count;
  logic [15:0]       streak, best_streak;
  logic [3:0]        log_fill;
`ifdef D20_TALLY_SUM_EN
  logic signed [23:0] sum_final;
`endif

  d20_roll_tally dut (
    .clk(clk), .reset(reset), .roll_valid(roll_valid), .random_num(random_num),
    .final_num(final_num), .hit(hit), .clear(clear), .rd_req(rd_req), .rd_age(rd_age),
    .rd_valid(rd_valid), .rd_err(rd_err), .rd_face(rd_face), .rd_final(rd_final),
    .rd_hit(rd_hit), .roll_count(roll_count), .hit_count(hit_count),
    .nat20_count(nat20_count), .nat1_count(nat1_count), .bad_count(bad_count),
    .streak(streak), .best_streak(best_streak),
`ifdef D20_TALLY_SUM_EN
    .sum_final(sum_final),
`endif
    .log_fill(log_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int face;
    int fin;
    int hit;
  } ent_t;

  ent_t log_q[$];
  int m_roll, m_hit, m_n20, m_n1, m_bad, m_streak, m_best, m_sum;
  bit m_busy;
  int m_err, m_face, m_fin, m_rhit;
  int n_checks, n_fail;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_clear();
    log_q.delete();
    m_roll = 0; m_hit = 0; m_n20 = 0; m_n1 = 0; m_bad = 0;
    m_streak = 0; m_best = 0; m_sum = 0;
    m_busy = 1'b0; m_err = 0; m_face = 0; m_fin = 0; m_rhit = 0;
  endtask

  task automatic model_roll(input int face, input int fin, input int h);
    ent_t e;
    if (face < 1 || face > 20) begin
      m_bad = sat(m_bad + 1);
      return;
    end
    m_roll = sat(m_roll + 1);
    if (face == 20) m_n20 = sat(m_n20 + 1);
    if (face == 1)  m_n1  = sat(m_n1 + 1);
    if (h != 0) begin
      m_hit    = sat(m_hit + 1);
      m_streak = sat(m_streak + 1);
      if (m_streak > m_best) m_best = m_streak;
    end else begin
      m_streak = 0;
    end
    m_sum += fin;
    e.face = face; e.fin = fin; e.hit = h;
    log_q.push_front(e);
    if (log_q.size() > DEPTH) void'(log_q.pop_back());
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    chk("rd_valid", rd_valid, int'(m_busy));
    chk("rd_err", rd_err, m_err);
    chk("rd_face", rd_face, m_face);
    chk("rd_final", rd_final, m_fin);
    chk("rd_hit", rd_hit, m_rhit);
    chk("roll_count", roll_count, m_roll);
    chk("hit_count", hit_count, m_hit);
    chk("nat20_count", nat20_count, m_n20);
    chk("nat1_count", nat1_count, m_n1);
    chk("bad_count", bad_count, m_bad);
    chk("streak", streak, m_streak);
    chk("best_streak", best_streak, m_best);
    chk("log_fill", log_fill, log_q.size());
`ifdef D20_TALLY_SUM_EN
    chk("sum_final", sum_final, m_sum);
`endif
  endtask

  // One clock of stimulus; the expected read is taken from the log before this cycle's roll
  task automatic step(input bit do_roll, input int face, input int fin, input int h,
                      input bit do_rd, input int age, input bit do_clr);
    bit accepted;
    roll_valid = do_roll;
    random_num = face[4:0];
    final_num  = fin[7:0];
    hit        = (h != 0);
    rd_req     = do_rd;
    rd_age     = age[2:0];
    clear      = do_clr;
    accepted   = do_rd && !m_busy && !do_clr;
    if (accepted) begin
      if (age >= log_q.size()) begin
        m_err = 1; m_face = 0; m_fin = 0; m_rhit = 0;
      end else begin
        m_err = 0; m_face = log_q[age].face; m_fin = log_q[age].fin; m_rhit = log_q[age].hit;
      end
    end
    cyc();
    roll_valid = 1'b0; rd_req = 1'b0; clear = 1'b0;
    if (do_clr) model_clear();
    else if (do_roll) model_roll(face, fin, h);
    m_busy = accepted;
    $display("step roll=%0d face=%0d fin=%0d hit=%0d rd=%0d age=%0d clr=%0d -> rd_valid=%0d rd_face=%0d rolls=%0d fill=%0d",
             do_roll, face, fin, h, do_rd, age, do_clr, rd_valid, rd_face, roll_count, log_fill);
    check_all();
  endtask

  task automatic roll(input int face, input int fin, input int h);
    step(1'b1, face, fin, h, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int age);
    step(1'b0, 0, 0, 0, 1'b1, age, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int f, v, h;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; roll_valid = 1'b0; random_num = '0; final_num = '0; hit = 1'b0;
    clear = 1'b0; rd_req = 1'b0; rd_age = '0;
    model_clear();
    cyc(); cyc();
    reset = 1'b0;

    // Reset state and empty-log read
    repeat (5) idle();
    rd(0);
    chk("empty_read_err", rd_err, 1);
    idle();

    // Basic stats
    roll(20, 25, 1); roll(7, 4, 0); roll(1, -2, 0); roll(14, 14, 1);
    chk("plan_rolls", roll_count, 4);
    chk("plan_best", best_streak, 1);
    rd(2);
    chk("plan_age2_face", rd_face, 7);
    idle();

    // Wrap-around of the log
    for (int i = 1; i <= 10; i++) roll(i, i, 0);
    chk("wrap_fill", log_fill, 8);
    rd(0); chk("wrap_age0_face", rd_face, 10); idle();
    rd(7); chk("wrap_age7_face", rd_face, 3); idle();

    // Invalid faces and streaks
    roll(0, 3, 1); roll(25, 3, 1);
    chk("bad_count", bad_count, 2);
    roll(15, 1, 1); roll(15, 1, 1); roll(15, 1, 1); roll(15, 1, 0);
    roll(15, 1, 1); roll(15, 1, 1);
    chk("streak_best", best_streak, 3);
    chk("streak_cur", streak, 2);

    // Read/write collision and back-to-back requests (second ignored)
    roll(5, -7, 1);
    step(1'b1, 9, 11, 0, 1'b1, 0, 1'b0);
    chk("collide_face", rd_face, 5);
    rd(0);
    rd(0);
    rd(0);
    chk("after_collide_face", rd_face, 9);
    idle();

    // Random rolls, reads and occasional clears
    for (int i = 0; i < 150; i++) begin
      f = int'($urandom_range(0, 31));
      v = int'($urandom_range(0, 255)) - 128;
      h = int'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, f, v, h, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 39) == 0);
    end
    idle();

    // clear wins over a same-cycle roll and read
    step(1'b1, 12, 5, 1, 1'b1, 0, 1'b1);
    chk("clear_rolls", roll_count, 0);
    chk("clear_fill", log_fill, 0);
    roll(4, -3, 0); roll(6, 10, 1);
`ifdef D20_TALLY_SUM_EN
    chk("sum_after_clear", sum_final, 7);
`endif

    // Reset while a response is on the outputs
    rd(0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_clear();
    $display("reset in RD_RESP -> rd_valid=%0d rd_face=%0d rolls=%0d", rd_valid, rd_face, roll_count);
    check_all();
    rd(0);
    chk("post_reset_err", rd_err, 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
